// File: rtl/vec3_div_if.sv
// Operand/result bus for the vec3 FP32 divider.
//
// Handshake semantics (both channels): a transfer happens on a rising clk
// edge where the producer's *_vld and the consumer's *_rdy are both high.
// The producer keeps *_vld and its payload stable until that edge. The
// consumer may raise or lower *_rdy at any time. a and b are only meaningful
// in the accept cycle. result stays stable while result_vld is high and
// result_rdy is low, and keeps its last value after the transfer.
//
// Vector layout for a, b and result: {x[95:64], y[63:32], z[31:0]}, each
// component an IEEE-754 binary32 value.
interface vec3_div_if;
   logic        op_vld;
   logic        op_rdy;
   logic [95:0] a;
   logic [95:0] b;
   logic        result_vld;
   logic        result_rdy;
   logic [95:0] result;

   modport master (
      output op_vld, a, b, result_rdy,
      input  op_rdy, result_vld, result
   );

   modport slave (
      input  op_vld, a, b, result_rdy,
      output op_rdy, result_vld, result
   );
endinterface

// File: rtl/vec3_div.sv
// Component-wise FP32 vector divide: result = a / b per component.
// One shared restoring divider processes x, then y, then z. Every component
// takes SETUP + 26/QBITS_PER_CLK DIV cycles + ROUND, so latency is fixed no
// matter which special cases occur. QBITS_PER_CLK must be 1 or 2.
// Denormal inputs flush to zero; underflowing results flush to zero.
module vec3_div #(
   parameter int QBITS_PER_CLK = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   vec3_div_if.slave   bus,
   output logic [2:0]  state_dbg
);

   localparam int         DIV_CYC  = 26 / QBITS_PER_CLK;
   localparam logic [4:0] DIV_LAST = 5'(DIV_CYC - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_SETUP = 3'd1,
      S_DIV   = 3'd2,
      S_ROUND = 3'd3,
      S_DONE  = 3'd4
   } state_t;

   // Outcome decided at SETUP; anything but SP_NONE overrides the datapath.
   typedef enum logic [1:0] {
      SP_NONE = 2'd0,
      SP_NAN  = 2'd1,
      SP_INF  = 2'd2,
      SP_ZERO = 2'd3
   } spec_t;

   state_t      state;
   logic [1:0]  comp;          // 0 = x, 1 = y, 2 = z
   logic [95:0] a_q;
   logic [95:0] b_q;
   logic        sign_q;
   spec_t       spec_q;
   logic [9:0]  exp_q;         // two's complement biased exponent
   logic [23:0] mb_q;
   logic [25:0] rem_q;
   logic [25:0] quo_q;
   logic [4:0]  cnt_q;
   logic        op_rdy_q;
   logic        result_vld_q;
   logic [95:0] result_q;

   // Component currently being worked on
   logic [31:0] a_c;
   logic [31:0] b_c;

   // SETUP decode
   logic [7:0]  ea;
   logic [7:0]  eb;
   logic [23:0] ma;
   logic [23:0] mb;
   logic        a_zero, b_zero, a_inf, b_inf, a_nan, b_nan;
   logic        pre_shift;
   logic [9:0]  exp_setup;
   logic [25:0] rem_init;
   spec_t       spec_setup;

   // DIV step
   logic [25:0] rem_n;
   logic [25:0] quo_n;

   // ROUND
   logic [23:0] mant;
   logic        guard_b;
   logic        round_b;
   logic        sticky_b;
   logic        round_up;
   logic [24:0] mant_sum;
   logic [22:0] frac_r;
   logic [9:0]  exp_r;
   logic [31:0] packed_r;

   // Select the active component from the latched operands
   always_comb begin
      a_c = a_q[95:64];
      b_c = b_q[95:64];
      case (comp)
         2'd1: begin
            a_c = a_q[63:32];
            b_c = b_q[63:32];
         end
         2'd2: begin
            a_c = a_q[31:0];
            b_c = b_q[31:0];
         end
         default: begin
            a_c = a_q[95:64];
            b_c = b_q[95:64];
         end
      endcase
   end

   // Unpack, classify specials, compute exponent and prenormalised remainder
   always_comb begin
      ea     = a_c[30:23];
      eb     = b_c[30:23];
      ma     = {1'b1, a_c[22:0]};
      mb     = {1'b1, b_c[22:0]};
      a_zero = (ea == 8'h00);
      b_zero = (eb == 8'h00);
      a_inf  = (ea == 8'hFF) && (a_c[22:0] == 23'd0);
      b_inf  = (eb == 8'hFF) && (b_c[22:0] == 23'd0);
      a_nan  = (ea == 8'hFF) && (a_c[22:0] != 23'd0);
      b_nan  = (eb == 8'hFF) && (b_c[22:0] != 23'd0);
      // A dividend mantissa below the divisor's is doubled so the quotient
      // always lands in [1,2) and its first bit is the integer bit.
      pre_shift = (ma < mb);
      exp_setup = 10'(ea) - 10'(eb) + 10'd127 - {9'd0, pre_shift};
      rem_init  = pre_shift ? {1'b0, ma, 1'b0} : {2'b00, ma};
      if (a_nan || b_nan || (a_zero && b_zero) || (a_inf && b_inf)) begin
         spec_setup = SP_NAN;
      end else if (a_inf || b_zero) begin
         spec_setup = SP_INF;
      end else if (b_inf || a_zero) begin
         spec_setup = SP_ZERO;
      end else begin
         spec_setup = SP_NONE;
      end
   end

   // Retire QBITS_PER_CLK restoring-division quotient bits
   always_comb begin
      rem_n = rem_q;
      quo_n = quo_q;
      for (int i = 0; i < QBITS_PER_CLK; i++) begin
         if (rem_n >= {2'b00, mb_q}) begin
            quo_n = {quo_n[24:0], 1'b1};
            rem_n = (rem_n - {2'b00, mb_q}) << 1;
         end else begin
            quo_n = {quo_n[24:0], 1'b0};
            rem_n = rem_n << 1;
         end
      end
   end

   // Round to nearest even, renormalise on carry-out, and pack
   always_comb begin
      mant     = quo_q[25:2];
      guard_b  = quo_q[1];
      round_b  = quo_q[0];
      sticky_b = |rem_q;
      round_up = guard_b & (round_b | sticky_b | mant[0]);
      mant_sum = {1'b0, mant} + {24'd0, round_up};
      if (mant_sum[24]) begin
         frac_r = mant_sum[23:1];
         exp_r  = exp_q + 10'd1;
      end else begin
         frac_r = mant_sum[22:0];
         exp_r  = exp_q;
      end
      case (spec_q)
         SP_NAN:  packed_r = 32'h7FC0_0000;
         SP_INF:  packed_r = {sign_q, 8'hFF, 23'd0};
         SP_ZERO: packed_r = {sign_q, 31'd0};
         default: begin
            if ($signed(exp_r) >= $signed(10'd255)) begin
               packed_r = {sign_q, 8'hFF, 23'd0};
            end else if ($signed(exp_r) <= $signed(10'd0)) begin
               packed_r = {sign_q, 31'd0};
            end else begin
               packed_r = {sign_q, exp_r[7:0], frac_r};
            end
         end
      endcase
   end

   // Control FSM plus datapath registers and registered handshake outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= S_IDLE;
         comp         <= 2'd0;
         a_q          <= '0;
         b_q          <= '0;
         sign_q       <= 1'b0;
         spec_q       <= SP_NONE;
         exp_q        <= '0;
         mb_q         <= '0;
         rem_q        <= '0;
         quo_q        <= '0;
         cnt_q        <= '0;
         op_rdy_q     <= 1'b1;
         result_vld_q <= 1'b0;
         result_q     <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (bus.op_vld && op_rdy_q) begin
                  a_q      <= bus.a;
                  b_q      <= bus.b;
                  comp     <= 2'd0;
                  op_rdy_q <= 1'b0;
                  state    <= S_SETUP;
               end
            end
            S_SETUP: begin
               sign_q <= a_c[31] ^ b_c[31];
               spec_q <= spec_setup;
               exp_q  <= exp_setup;
               mb_q   <= mb;
               rem_q  <= rem_init;
               quo_q  <= '0;
               cnt_q  <= '0;
               state  <= S_DIV;
            end
            S_DIV: begin
               rem_q <= rem_n;
               quo_q <= quo_n;
               cnt_q <= cnt_q + 5'd1;
               if (cnt_q == DIV_LAST) begin
                  state <= S_ROUND;
               end
            end
            S_ROUND: begin
               case (comp)
                  2'd0:    result_q[95:64] <= packed_r;
                  2'd1:    result_q[63:32] <= packed_r;
                  default: result_q[31:0]  <= packed_r;
               endcase
               if (comp == 2'd2) begin
                  result_vld_q <= 1'b1;
                  state        <= S_DONE;
               end else begin
                  comp  <= comp + 2'd1;
                  state <= S_SETUP;
               end
            end
            S_DONE: begin
               // op_rdy rises only after the handshake edge, so a new op can
               // never be taken in the same cycle the result leaves.
               if (bus.result_rdy) begin
                  result_vld_q <= 1'b0;
                  op_rdy_q     <= 1'b1;
                  state        <= S_IDLE;
               end
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.op_rdy     = op_rdy_q;
   assign bus.result_vld = result_vld_q;
   assign bus.result     = result_q;
   assign state_dbg      = state;

endmodule

// File: tb/tb_vec3_div.sv
// Bench for vec3_div: directed cases plus randomized vectors scored against
// an integer-arithmetic FP32 divide model.
module tb_vec3_div;

   localparam int QB  = 1;
   localparam int LAT = 3 * (2 + 26 / QB);

   // ---------------- clock / reset ----------------
   logic       clk   = 1'b0;
   logic       rst_n = 1'b1;
   logic [2:0] state_dbg;

   always #5 clk = ~clk;

   vec3_div_if bus ();

   vec3_div #(.QBITS_PER_CLK(QB)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus),
      .state_dbg (state_dbg)
   );

   // ---------------- scoreboard ----------------
   int          n_cmp = 0;
   int          n_err = 0;
   logic [95:0] exp_q[$];

   task automatic check(input string tag, input logic [95:0] got, input logic [95:0] want);
      n_cmp++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, want);
      end
   endtask

   // ---------------- reference model ----------------
   // Exact long division of the mantissas, then round-to-nearest-even.
   function automatic logic [31:0] ref_div(input logic [31:0] a, input logic [31:0] b);
      int          ea, eb, e, sh;
      bit          sgn, a0, b0, ainf, binf, anan, bnan;
      longint unsigned ma, mb, num, q, rem, kept, rest, half;
      ea   = int'(a[30:23]);
      eb   = int'(b[30:23]);
      sgn  = a[31] ^ b[31];
      a0   = (ea == 0);
      b0   = (eb == 0);
      ainf = (ea == 255) && (a[22:0] == 0);
      binf = (eb == 255) && (b[22:0] == 0);
      anan = (ea == 255) && (a[22:0] != 0);
      bnan = (eb == 255) && (b[22:0] != 0);
      if (anan || bnan || (a0 && b0) || (ainf && binf)) return 32'h7FC0_0000;
      if (ainf || b0) return {sgn, 8'hFF, 23'h0};
      if (binf || a0) return {sgn, 31'h0};
      ma  = 64'h80_0000 | 64'(a[22:0]);
      mb  = 64'h80_0000 | 64'(b[22:0]);
      num = ma << 30;
      q   = num / mb;
      rem = num % mb;
      if (q >= (64'd1 << 30)) begin
         sh = 7;
         e  = ea - eb + 127;
      end else begin
         sh = 6;
         e  = ea - eb + 126;
      end
      kept = q >> sh;
      rest = q & ((64'd1 << sh) - 1);
      half = 64'd1 << (sh - 1);
      if (rest > half || (rest == half && (rem != 0 || kept[0]))) kept++;
      if (kept == (64'd1 << 24)) begin
         kept = kept >> 1;
         e++;
      end
      if (e >= 255) return {sgn, 8'hFF, 23'h0};
      if (e <= 0) return {sgn, 31'h0};
      return {sgn, e[7:0], kept[22:0]};
   endfunction

   function automatic logic [95:0] ref_vec(input logic [95:0] a, input logic [95:0] b);
      return {ref_div(a[95:64], b[95:64]), ref_div(a[63:32], b[63:32]), ref_div(a[31:0], b[31:0])};
   endfunction

   function automatic logic [31:0] rnd_f();
      logic [31:0] v;
      int          k;
      v = $urandom;
      k = $urandom_range(0, 19);
      case (k)
         0: v[30:0] = 31'd0;
         1: begin
            v[30:23] = 8'hFF;
            v[22:0]  = 23'd0;
         end
         2: begin
            v[30:23] = 8'hFF;
            v[22]    = 1'b1;
         end
         3: v[30:23] = 8'h00;
         4, 5: ;
         default: v[30:23] = 8'($urandom_range(100, 154));
      endcase
      return v;
   endfunction

   function automatic logic [95:0] rnd_vec();
      return {rnd_f(), rnd_f(), rnd_f()};
   endfunction

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_op(input string tag, input logic [95:0] a, input logic [95:0] b);
      int wait_cyc;
      wait_cyc   = 0;
      bus.a      = a;
      bus.b      = b;
      bus.op_vld = 1'b1;
      while (!bus.op_rdy && wait_cyc < 500) begin
         tick();
         wait_cyc++;
      end
      if (!bus.op_rdy) check({tag, "_op_rdy_timeout"}, 96'(bus.op_rdy), 96'd1);
      tick();
      exp_q.push_back(ref_vec(a, b));
      bus.op_vld = 1'b0;
      bus.a      = {$urandom, $urandom, $urandom};
      bus.b      = {$urandom, $urandom, $urandom};
   endtask

   task automatic wait_vld(input string tag);
      int          cyc;
      logic [95:0] want;
      cyc = 0;
      while (!bus.result_vld && cyc < 400) begin
         tick();
         cyc++;
      end
      check({tag, "_latency"}, 96'(cyc), 96'(LAT));
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 96'd0;
      check({tag, "_result"}, bus.result, want);
      exp_q.push_front(want);
   endtask

   task automatic take_result(input string tag);
      logic [95:0] want;
      want = (exp_q.size() != 0) ? exp_q.pop_front() : 96'd0;
      bus.result_rdy = 1'b1;
      tick();
      bus.result_rdy = 1'b0;
      check({tag, "_vld_clr"}, 96'(bus.result_vld), 96'd0);
      check({tag, "_op_rdy"}, 96'(bus.op_rdy), 96'd1);
      check({tag, "_held"}, bus.result, want);
   endtask

   task automatic run_op(input string tag, input logic [95:0] a, input logic [95:0] b);
      send_op(tag, a, b);
      wait_vld(tag);
      take_result(tag);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      logic [95:0] a5, b5, w5;
      bit          seen;
      bus.op_vld     = 1'b0;
      bus.a          = '0;
      bus.b          = '0;
      bus.result_rdy = 1'b0;
      #2 rst_n = 1'b0;
      repeat (3) tick();
      check("rst_op_rdy", 96'(bus.op_rdy), 96'd1);
      check("rst_result_vld", 96'(bus.result_vld), 96'd0);
      check("rst_result", bus.result, 96'd0);
      rst_n = 1'b1;
      tick();

      // Basic divide
      run_op("t1", {32'h40C0_0000, 32'h4100_0000, 32'h3F80_0000},
                   {32'h4000_0000, 32'h4080_0000, 32'h3F00_0000});
      check("t1_const", bus.result, {32'h4040_0000, 32'h4000_0000, 32'h4000_0000});

      // Divide by zero and 0/0
      run_op("t2", {32'h3F80_0000, 32'hBF80_0000, 32'h0000_0000}, 96'd0);
      check("t2_const", bus.result, {32'h7F80_0000, 32'hFF80_0000, 32'h7FC0_0000});

      // Rounding
      run_op("t3", {32'h3F80_0000, 32'h4000_0000, 32'h3F80_0000},
                   {32'h4040_0000, 32'h4040_0000, 32'h40E0_0000});
      check("t3_const", bus.result, {32'h3EAA_AAAB, 32'h3F2A_AAAB, 32'h3E12_4925});

      // Overflow / underflow
      run_op("t4", {32'h7F00_0000, 32'h0080_0000, 32'h3F80_0000},
                   {32'h3E80_0000, 32'h4000_0000, 32'h3F80_0000});
      check("t4_const", bus.result, {32'h7F80_0000, 32'h0000_0000, 32'h3F80_0000});

      // Backpressure with an ignored op_vld pulse
      a5 = {32'h4120_0000, 32'hC0A0_0000, 32'h3E00_0000};
      b5 = {32'h4000_0000, 32'h3FC0_0000, 32'hC100_0000};
      w5 = ref_vec(a5, b5);
      send_op("t5", a5, b5);
      wait_vld("t5");
      for (int i = 0; i < 10; i++) begin
         bus.op_vld = (i == 3 || i == 4);
         bus.a      = {$urandom, $urandom, $urandom};
         bus.b      = {$urandom, $urandom, $urandom};
         tick();
         check("t5_bp_result", bus.result, w5);
         check("t5_bp_vld", 96'(bus.result_vld), 96'd1);
         check("t5_bp_op_rdy", 96'(bus.op_rdy), 96'd0);
      end
      bus.op_vld = 1'b0;
      take_result("t5");
      for (int i = 0; i < 3; i++) run_op("t5_b2b", rnd_vec(), rnd_vec());

      // Reset in the middle of an op
      send_op("t6", rnd_vec(), rnd_vec());
      repeat (40) tick();
      rst_n = 1'b0;
      #1;
      check("t6_rst_op_rdy", 96'(bus.op_rdy), 96'd1);
      check("t6_rst_vld", 96'(bus.result_vld), 96'd0);
      check("t6_rst_result", bus.result, 96'd0);
      exp_q.delete();
      tick();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < LAT + 10; i++) begin
         tick();
         seen |= bus.result_vld;
      end
      check("t6_no_stale_vld", 96'(seen), 96'd0);
      run_op("t6_after", {32'h40C0_0000, 32'h4100_0000, 32'h3F80_0000},
                         {32'h4000_0000, 32'h4080_0000, 32'h3F00_0000});

      // Randomized
      for (int i = 0; i < 40; i++) run_op("rand", rnd_vec(), rnd_vec());

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   // Absolute time bound on the whole run
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
